// File: rtl/core_pkg.sv
// core_pkg: types and constants shared by the decode stage.
//   opclass_t   - decoded operation class driven on out_op
//   OPC_*       - RV32I major opcodes (instr[6:0])
//   dec_state_t - decode sequencer states
package core_pkg;

  typedef enum logic [3:0] {
    LUI     = 4'd0,
    AUIPC   = 4'd1,
    JAL     = 4'd2,
    JALR    = 4'd3,
    BRANCH  = 4'd4,
    LOAD    = 4'd5,
    STORE   = 4'd6,
    OPIMM   = 4'd7,
    OP      = 4'd8,
    SYSTEM  = 4'd9,
    ILLEGAL = 4'd10
  } opclass_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // RD0/RD1 cover the register file's two registered read stages.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD0  = 3'd1,
    RD1  = 3'd2,
    CAP  = 3'd3,
    OUT  = 3'd4
  } dec_state_t;

endpackage

// File: rtl/instr_decode_imm_gen.sv
// imm_gen: purely combinational classifier / immediate generator.
//   instr   in  32  raw RV32I instruction word
//   op      out     op class (ILLEGAL for unknown encodings)
//   imm     out 32  sign-extended immediate (0 for OP, SYSTEM, ILLEGAL)
//   illegal out 1   unrecognised encoding
module imm_gen
  import core_pkg::*;
(
  input  logic [31:0] instr,
  output opclass_t    op,
  output logic [31:0] imm,
  output logic        illegal
);

  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  always_comb begin
    op      = ILLEGAL;
    imm     = '0;
    illegal = 1'b1;
    // Compressed / non-32-bit encodings fall through as illegal.
    if (instr[1:0] == 2'b11) begin
      illegal = 1'b0;
      case (instr[6:0])
        OPC_LUI:    begin op = LUI;    imm = imm_u; end
        OPC_AUIPC:  begin op = AUIPC;  imm = imm_u; end
        OPC_JAL:    begin op = JAL;    imm = imm_j; end
        OPC_JALR:   begin op = JALR;   imm = imm_i; end
        OPC_BRANCH: begin op = BRANCH; imm = imm_b; end
        OPC_LOAD:   begin op = LOAD;   imm = imm_i; end
        OPC_STORE:  begin op = STORE;  imm = imm_s; end
        OPC_OPIMM:  begin op = OPIMM;  imm = imm_i; end
        OPC_OP:     begin op = OP;     end
        OPC_SYSTEM: begin op = SYSTEM; end
        default:    begin illegal = 1'b1; end
      endcase
    end
  end

endmodule

// File: rtl/instr_decode.sv
// instr_decode: decode stage between fetch and execute.
//   clk, rst                  core clock, asynchronous active-high reset
//   instr_valid/instr_ready   fetch handshake (ready only in IDLE)
//   instr, pc                 instruction word and its address
//   rf_rs1, rf_rs2            register file read addresses
//   rf_rs1v, rf_rs2v          register file read data (2-cycle latency)
//   out_valid/out_ready       execute handshake
//   out_*                     decoded bundle, held stable while in OUT
module instr_decode
  import core_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  output logic [4:0]  rf_rs1,
  output logic [4:0]  rf_rs2,
  input  logic [31:0] rf_rs1v,
  input  logic [31:0] rf_rs2v,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [3:0]  out_op,
  output logic [2:0]  out_funct3,
  output logic        out_funct7b5,
  output logic [4:0]  out_rd,
  output logic [31:0] out_rs1v,
  output logic [31:0] out_rs2v,
  output logic [31:0] out_imm,
  output logic        out_illegal
);

  dec_state_t  state_reg;
  dec_state_t  state_next;

  logic [31:0] instr_reg;
  logic [31:0] pc_reg;

  opclass_t    gen_op;
  logic [31:0] gen_imm;
  logic        gen_illegal;

  opclass_t    out_op_reg;
  logic [31:0] out_pc_reg;
  logic [2:0]  out_funct3_reg;
  logic        out_funct7b5_reg;
  logic [4:0]  out_rd_reg;
  logic [31:0] out_rs1v_reg;
  logic [31:0] out_rs2v_reg;
  logic [31:0] out_imm_reg;
  logic        out_illegal_reg;

  imm_gen u_imm_gen (
    .instr   (instr_reg),
    .op      (gen_op),
    .imm     (gen_imm),
    .illegal (gen_illegal)
  );

  // instr_reg only changes in IDLE, so the addresses stay put RD0..CAP.
  assign rf_rs1 = instr_reg[19:15];
  assign rf_rs2 = instr_reg[24:20];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    instr_ready = 1'b0;
    out_valid   = 1'b0;
    case (state_reg)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_next = RD0;
      end
      RD0: state_next = RD1;
      RD1: state_next = CAP;
      CAP: state_next = OUT;
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_reg <= '0;
      pc_reg    <= '0;
    end else if (state_reg == IDLE && instr_valid) begin
      instr_reg <= instr;
      pc_reg    <= pc;
    end
  end

  // The bundle is written only in CAP, which makes it hold through any OUT stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_op_reg       <= LUI;
      out_pc_reg       <= '0;
      out_funct3_reg   <= '0;
      out_funct7b5_reg <= 1'b0;
      out_rd_reg       <= '0;
      out_rs1v_reg     <= '0;
      out_rs2v_reg     <= '0;
      out_imm_reg      <= '0;
      out_illegal_reg  <= 1'b0;
    end else if (state_reg == CAP) begin
      out_op_reg       <= gen_op;
      out_pc_reg       <= pc_reg;
      out_funct3_reg   <= instr_reg[14:12];
      out_funct7b5_reg <= instr_reg[30];
      out_rd_reg       <= instr_reg[11:7];
      out_rs1v_reg     <= rf_rs1v;
      out_rs2v_reg     <= rf_rs2v;
      out_imm_reg      <= gen_imm;
      out_illegal_reg  <= gen_illegal;
    end
  end

  assign out_op       = out_op_reg;
  assign out_pc       = out_pc_reg;
  assign out_funct3   = out_funct3_reg;
  assign out_funct7b5 = out_funct7b5_reg;
  assign out_rd       = out_rd_reg;
  assign out_rs1v     = out_rs1v_reg;
  assign out_rs2v     = out_rs2v_reg;
  assign out_imm      = out_imm_reg;
  assign out_illegal  = out_illegal_reg;

endmodule

// File: tb/tb_instr_decode.sv
module tb_instr_decode;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [4:0]  rf_rs1;
  logic [4:0]  rf_rs2;
  logic [31:0] rf_rs1v;
  logic [31:0] rf_rs2v;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [3:0]  out_op;
  logic [2:0]  out_funct3;
  logic        out_funct7b5;
  logic [4:0]  out_rd;
  logic [31:0] out_rs1v;
  logic [31:0] out_rs2v;
  logic [31:0] out_imm;
  logic        out_illegal;

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  op;
    logic [2:0]  f3;
    logic        f7b5;
    logic [4:0]  rd;
    logic [31:0] rs1v;
    logic [31:0] rs2v;
    logic [31:0] imm;
    logic        illegal;
  } bundle_t;

  bundle_t     sb[$];
  int          tests_run = 0;
  int          tests_failed = 0;
  int          cyc = 0;
  int          accept_cyc = 0;
  logic [31:0] rf_mem [32];
  logic [31:0] rf_s1;
  logic [31:0] rf_s2;

  instr_decode dut (
    .clk          (clk),
    .rst          (rst),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr        (instr),
    .pc           (pc),
    .rf_rs1       (rf_rs1),
    .rf_rs2       (rf_rs2),
    .rf_rs1v      (rf_rs1v),
    .rf_rs2v      (rf_rs2v),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pc       (out_pc),
    .out_op       (out_op),
    .out_funct3   (out_funct3),
    .out_funct7b5 (out_funct7b5),
    .out_rd       (out_rd),
    .out_rs1v     (out_rs1v),
    .out_rs2v     (out_rs2v),
    .out_imm      (out_imm),
    .out_illegal  (out_illegal)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Register file model: two registered read stages, x0 hard-wired to zero.
  always @(posedge clk) begin
    rf_s1   <= (rf_rs1 == 5'd0) ? 32'd0 : rf_mem[rf_rs1];
    rf_s2   <= (rf_rs2 == 5'd0) ? 32'd0 : rf_mem[rf_rs2];
    rf_rs1v <= rf_s1;
    rf_rs2v <= rf_s2;
  end

  function automatic bundle_t sample_out();
    bundle_t b;
    b = '{out_pc, out_op, out_funct3, out_funct7b5, out_rd,
          out_rs1v, out_rs2v, out_imm, out_illegal};
    return b;
  endfunction

  // Fields are sliced from the stimulus word; op/imm come from the caller.
  function automatic bundle_t mk_exp(input logic [31:0] i, input logic [31:0] p,
                                     input opclass_t op, input logic [31:0] imm,
                                     input logic ill);
    bundle_t b;
    b.pc      = p;
    b.op      = op;
    b.f3      = i[14:12];
    b.f7b5    = i[30];
    b.rd      = i[11:7];
    b.rs1v    = (i[19:15] == 5'd0) ? 32'd0 : rf_mem[i[19:15]];
    b.rs2v    = (i[24:20] == 5'd0) ? 32'd0 : rf_mem[i[24:20]];
    b.imm     = imm;
    b.illegal = ill;
    return b;
  endfunction

  // Present one instruction and return #1 after its accept edge.
  task automatic send(input logic [31:0] i, input logic [31:0] p);
    int n;
    @(negedge clk);
    instr_valid = 1'b1;
    instr       = i;
    pc          = p;
    n = 0;
    while (!instr_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    accept_cyc  = cyc;
    instr_valid = 1'b0;
  endtask

  // Edges after the accept edge until out_valid is seen (bounded).
  task automatic wait_out(output int edges);
    edges = 0;
    while (!out_valid && edges < 20) begin
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || instr_ready !== 1'b1 || rf_rs1 !== 5'd0 || rf_rs2 !== 5'd0 ||
        sample_out() !== '0) begin
      tests_failed++;
      $display("FAIL reset: valid=%b ready=%b rs1=%0d rs2=%0d bundle=%h, required 0 1 0 0 all-zero",
               out_valid, instr_ready, rf_rs1, rf_rs2, sample_out());
    end else $display("[TB] reset ok");
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One decode with out_ready high; checks latency (accept cycle = cycle 1) and bundle.
  task automatic test_one(input string name, input logic [31:0] i, input logic [31:0] p,
                          input opclass_t op, input logic [31:0] imm, input logic ill);
    int e;
    bundle_t exp, obs;
    out_ready = 1'b1;
    sb.push_back(mk_exp(i, p, op, imm, ill));
    send(i, p);
    wait_out(e);
    tests_run++;
    if (!out_valid || e + 1 != 4) begin
      tests_failed++;
      $display("FAIL %s latency: out_valid=%b after %0d cycles, required 4", name, out_valid, e + 1);
    end
    exp = sb.pop_front();
    obs = sample_out();
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s bundle: got %h, required %h", name, obs, exp);
    end else $display("[TB] %s instr=%h op=%0d imm=%h ok", name, i, obs.op, obs.imm);
    @(posedge clk);
    #1;
    tests_run++;
    if (instr_ready !== 1'b1 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s handshake: ready=%b valid=%b, required 1 0", name, instr_ready, out_valid);
    end
  endtask

  task automatic test_addi();
    rf_mem[1] = 32'h0000_0010;
    test_one("addi", 32'hFFD0_8293, 32'h0000_0100, OPIMM, 32'hFFFF_FFFD, 1'b0);
  endtask

  task automatic test_store();
    rf_mem[2] = 32'hAAAA_5555;
    rf_mem[3] = 32'h0000_0100;
    test_one("sw", 32'h0021_A423, 32'h0000_0104, STORE, 32'h0000_0008, 1'b0);
  endtask

  task automatic test_back_to_back();
    int first;
    test_one("lui", 32'h1234_53B7, 32'h0000_0108, LUI, 32'h1234_5000, 1'b0);
    first = accept_cyc;
    test_one("beq", 32'hFE00_0EE3, 32'h0000_010C, BRANCH, 32'hFFFF_FFFC, 1'b0);
    tests_run++;
    if (accept_cyc - first != 5) begin
      tests_failed++;
      $display("FAIL issue_interval: got %0d cycles, required 5", accept_cyc - first);
    end else $display("[TB] issue interval 5 ok");
  endtask

  task automatic test_stall();
    int e;
    int bad;
    bundle_t exp;
    rf_mem[1] = 32'h0000_0010;
    out_ready = 1'b0;
    sb.push_back(mk_exp(32'hFFD0_8293, 32'h0000_0200, OPIMM, 32'hFFFF_FFFD, 1'b0));
    send(32'hFFD0_8293, 32'h0000_0200);
    wait_out(e);
    exp = sb[0];
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      rf_mem[1] = 32'hDEAD_0000 + k;
      @(posedge clk);
      #1;
      if (out_valid !== 1'b1 || instr_ready !== 1'b0 || sample_out() !== exp) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL stall_hold: %0d unstable cycles, last bundle %h, required %h", bad, sample_out(), exp);
    end else $display("[TB] stall 10 cycles stable ok");
    void'(sb.pop_front());
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    tests_run++;
    if (instr_ready !== 1'b1 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL stall_release: ready=%b valid=%b, required 1 0", instr_ready, out_valid);
    end else $display("[TB] stall release ok");
  endtask

  task automatic test_illegal();
    test_one("illegal", 32'h0000_0000, 32'h0000_0300, ILLEGAL, 32'h0, 1'b1);
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    sb.push_back(mk_exp(32'h0000_1297, 32'h0000_0400, AUIPC, 32'h0000_1000, 1'b0));
    send(32'h0000_1297, 32'h0000_0400);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || instr_ready !== 1'b1 || rf_rs1 !== 5'd0) begin
      tests_failed++;
      $display("FAIL reset_mid: valid=%b ready=%b rs1=%0d, required 0 1 0", out_valid, instr_ready, rf_rs1);
    end else $display("[TB] reset in RD1 ok");
    void'(sb.pop_front());
    @(negedge clk);
    rst = 1'b0;
    test_one("jal_after_rst", 32'h0080_006F, 32'h0000_0500, JAL, 32'h0000_0008, 1'b0);
  endtask

  initial begin
    for (int k = 0; k < 32; k++) rf_mem[k] = 32'd0;
    rst         = 1'b1;
    instr_valid = 1'b0;
    instr       = '0;
    pc          = '0;
    out_ready   = 1'b0;
    test_reset();
    test_addi();
    test_store();
    test_back_to_back();
    test_stall();
    test_illegal();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/instr_decode.md
# instr_decode

Decode stage for the multicycle core, placed directly upstream of the register file. It accepts one fetched instruction per handshake and drives the rs1/rs2 read addresses. It waits out the register file's two-cycle registered read latency, then captures the operands. It presents a fully decoded bundle (op class, fields, sign-extended immediate, operand values) to execute over a valid/ready handshake.

## Interface
- No parameters; XLEN fixed at 32.
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- instr_valid  in  1  fetch has an instruction
- instr_ready  out  1  decode can accept (high only in IDLE)
- instr  in  32  raw RV32I instruction word
- pc  in  32  address of instr
- rf_rs1  out  5  register file read address 1
- rf_rs2  out  5  register file read address 2
- rf_rs1v  in  32  register file read data 1 (2-cycle registered latency)
- rf_rs2v  in  32  register file read data 2
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  execute accepts bundle
- out_pc  out  32  captured pc
- out_op  out  4  op class (opclass_t)
- out_funct3  out  3  instr[14:12]
- out_funct7b5  out  1  instr[30]
- out_rd  out  5  instr[11:7]
- out_rs1v  out  32  operand 1
- out_rs2v  out  32  operand 2
- out_imm  out  32  sign-extended immediate
- out_illegal  out  1  unrecognised encoding

## Operation
- FSM states: IDLE, RD0, RD1, CAP, OUT.
- IDLE: instr_ready=1. When instr_valid, latch instr and pc into internal registers and go to RD0.
- rf_rs1 and rf_rs2 are driven combinationally from the latched instr[19:15] and [24:20]. They are held constant from RD0 through CAP.
- RD0 goes to RD1, and RD1 goes to CAP, unconditionally. These two states are the register file pipeline stages.
- CAP: register rf_rs1v/rf_rs2v and all decoded fields into the out_* registers, then go to OUT.
- OUT: out_valid=1. On out_ready, go to IDLE. Otherwise hold every out_* bit stable.
- Op classes: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OPIMM 0010011, OP 0110011, SYSTEM 1110011.
- Any other opcode, or instr[1:0]≠2'b11, sets out_op=ILLEGAL and out_illegal=1. The instruction still flows normally. out_imm=0 for illegal, OP and SYSTEM.
- Immediates:
  - I-type (JALR/LOAD/OPIMM): sext(instr[31:20]).
  - S-type: sext({[31:25],[11:7]}).
  - B-type: sext({[31],[7],[30:25],[11:8],1'b0}).
  - U-type: {[31:12],12'b0}.
  - J-type: sext({[31],[19:12],[20],[30:21],1'b0}).
- Operand values come straight from the register file. Decode does no x0 forcing; the register file guarantees x0 reads 0.
- Operands reflect register file contents at the clock edge ending RD0. Write-after-read hazards are the controller's concern, not decode's.

## Timing
- Accept edge A (instr_valid & instr_ready). rf_rs* are valid from A, register file data is valid during cycle A+2, and it is captured at edge A+3. out_valid rises after A+3.
- Latency from accept to out_valid is 4 cycles. The minimum issue interval is 5 cycles.
- instr_ready is low from A until the out handshake completes.
- Reset values, all zero: state=IDLE, instr_ready=1 (combinational from state), out_valid=0, all out_* = 0, rf_rs1=rf_rs2=0, internal instr/pc = 0.
- rst asserted mid-operation, in any state, returns to IDLE immediately. The in-flight instruction is discarded and not replayed.
- out_ready high outside OUT is ignored. instr_valid high outside IDLE is ignored; fetch must hold instr stable until accepted.

## Structure
- Shared package core_pkg: opclass_t enum (LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OPIMM, OP, SYSTEM, ILLEGAL), the opcode localparams, and the decode state enum.
- One sub-module, imm_gen: purely combinational instr → {opclass, imm, illegal}. It is instantiated once and its outputs are registered in CAP.

## Test plan
- RF x1=0x00000010, instr 0xFFD08293 (addi x5,x1,-3), out_ready=1 → out_valid exactly 4 cycles after accept. Expected bundle: op=OPIMM, rd=5, rs1v=0x10, imm=0xFFFFFFFD, funct3=0.
- x2=0xAAAA5555, x3=0x100, instr 0x0021A423 (sw x2,8(x3)) → op=STORE, imm=8, rs1v=0x100, rs2v=0xAAAA5555.
- instr 0x123453B7 (lui x7,0x12345) → op=LUI, imm=0x12345000, rd=7. Then 0xFE000EE3 (beq x0,x0,-4) → op=BRANCH, imm=0xFFFFFFFC.
- Hold out_ready=0 for 10 cycles in OUT, and write the source register in the register file meanwhile → out_* stable, instr_ready=0 throughout. Release out_ready → handshake completes and IDLE is reached next cycle.
- instr 0x00000000 → out_illegal=1, op=ILLEGAL, imm=0, normal 4-cycle latency.
- Assert rst in RD1 → out_valid=0 and instr_ready=1 immediately. The next instruction decodes correctly with 4-cycle latency.
